// File: rtl/riot_irq_ctrl.sv
// riot_irq_ctrl: control end of the MM6532 interval timer and PA7 edge detector.
// Decodes CPU timer and edge-control accesses. Holds the timer-underflow and
// PA7-edge flags with their enables, and drives the active-low IRQ_N.
module riot_irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic       RW,
    input  logic [4:0] A,
    input  logic       PA7,
    input  logic       TIM_UF,
    output logic       TIM_WE,
    output logic [1:0] TIM_MODE,
    output logic [7:0] FLAG_OUT,
    output logic       IRQ_N
);

    logic                   tim_flag;
    logic                   pa7_flag;
    logic                   tim_ie;
    logic                   pa7_ie;
    logic                   edge_pos;
    logic [SYNC_STAGES-1:0] pa7_sync;
    logic                   pa7_prev;
    logic                   pa7_s;
    logic                   pa7_edge;
    logic                   acc_tw;
    logic                   acc_tr;
    logic                   acc_fr;
    logic                   acc_ew;

    // Decode CPU accesses; everything with A[2]=0 is RAM/port space and ignored here
    always_comb begin
        acc_tw = CS & ~RW &  A[4] & A[2];
        acc_tr = CS &  RW &  A[2] & ~A[0];
        acc_fr = CS &  RW &  A[2] &  A[0];
        acc_ew = CS & ~RW & ~A[4] & A[2];
    end

    // Timer strobe and mode go straight to the timer in the access cycle; reset masks the strobe
    always_comb begin
        TIM_WE   = acc_tw & ~RES;
        TIM_MODE = A[1:0];
    end

    // Synchronise the asynchronous PA7 pin, then keep one older sample for edge detection
    always_ff @(posedge CLK) begin
        if (RES) begin
            pa7_sync <= '0;
            pa7_prev <= 1'b0;
        end else begin
            pa7_sync <= {pa7_sync[SYNC_STAGES-2:0], PA7};
            pa7_prev <= pa7_sync[SYNC_STAGES-1];
        end
    end

    // Edge compares two synchronised samples only, so a polarity change alone cannot fire
    always_comb begin
        pa7_s    = pa7_sync[SYNC_STAGES-1];
        pa7_edge = edge_pos ? (pa7_s & ~pa7_prev) : (~pa7_s & pa7_prev);
    end

    // Flags: a set event in the same cycle as a clearing access wins, so no event is lost
    always_ff @(posedge CLK) begin
        if (RES) begin
            tim_flag <= 1'b0;
            pa7_flag <= 1'b0;
        end else begin
            tim_flag <= TIM_UF   | (tim_flag & ~(acc_tw | acc_tr));
            pa7_flag <= pa7_edge | (pa7_flag & ~acc_fr);
        end
    end

    // Interrupt enables and edge polarity are loaded from the address bits of the access
    always_ff @(posedge CLK) begin
        if (RES) begin
            tim_ie   <= 1'b0;
            pa7_ie   <= 1'b0;
            edge_pos <= 1'b0;
        end else begin
            if (acc_tw | acc_tr) begin
                tim_ie <= A[3];
            end
            if (acc_ew) begin
                edge_pos <= A[0];
                pa7_ie   <= A[1];
            end
        end
    end

    // Flag read data is always driven and the parent gates it onto the bus; IRQ follows flags and enables
    always_comb begin
        FLAG_OUT = {tim_flag, pa7_flag, 6'b000000};
        IRQ_N    = ~((tim_flag & tim_ie) | (pa7_flag & pa7_ie));
    end

endmodule

// File: tb/tb_riot_irq_ctrl.sv
// tb_riot_irq_ctrl: directed scenarios plus randomized traffic against a
// behavioural model built from the register rules and a history of pin samples.
module tb_riot_irq_ctrl;

    localparam int SS = 2;

    logic       CLK;
    logic       RES;
    logic       CS;
    logic       RW;
    logic [4:0] A;
    logic       PA7;
    logic       TIM_UF;
    logic       TIM_WE;
    logic [1:0] TIM_MODE;
    logic [7:0] FLAG_OUT;
    logic       IRQ_N;

    int nCompared   = 0;
    int nMismatched = 0;

    bit mTimFlag, mPa7Flag, mTimIe, mPa7Ie, mEdgePos;
    bit samples[$];

    logic       obsWe;
    logic [1:0] obsMode;
    logic [7:0] obsFlag;
    logic       obsIrq;
    int         latency;

    riot_irq_ctrl #(.SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RES(RES), .CS(CS), .RW(RW), .A(A), .PA7(PA7),
        .TIM_UF(TIM_UF), .TIM_WE(TIM_WE), .TIM_MODE(TIM_MODE),
        .FLAG_OUT(FLAG_OUT), .IRQ_N(IRQ_N)
    );

    // Free-running clock, period 10
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, need $finish before limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, need 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mTimFlag = 0; mPa7Flag = 0; mTimIe = 0; mPa7Ie = 0; mEdgePos = 0;
        samples.delete();
        for (int i = 0; i <= SS; i++) samples.push_back(1'b0);
    endtask

    // One clock of the register rules; samples[0] is the newest pin sample
    task automatic modelStep(input bit cs, input bit rw, input bit [4:0] a,
                             input bit pa7, input bit uf, input bit res);
        bit tw, tr, fr, ew, s, prev, edgeHit;
        if (res) begin
            modelReset();
            return;
        end
        tw = cs && !rw && a[4] && a[2];
        tr = cs && rw && a[2] && !a[0];
        fr = cs && rw && a[2] && a[0];
        ew = cs && !rw && !a[4] && a[2];
        s    = samples[SS-1];
        prev = samples[SS];
        edgeHit = mEdgePos ? (s && !prev) : (!s && prev);
        if (uf) mTimFlag = 1;
        else if (tw || tr) mTimFlag = 0;
        if (edgeHit) mPa7Flag = 1;
        else if (fr) mPa7Flag = 0;
        if (tw || tr) mTimIe = a[3];
        if (ew) begin
            mEdgePos = a[0];
            mPa7Ie   = a[1];
        end
        samples.push_front(pa7);
        void'(samples.pop_back());
    endtask

    // Drive one cycle from the negedge, check outputs, then advance DUT and model together
    task automatic applyStimulus(input bit cs, input bit rw, input bit [4:0] a,
                                 input bit pa7, input bit uf, input bit res);
        bit expWe, expIrq;
        CS = cs; RW = rw; A = a; PA7 = pa7; TIM_UF = uf; RES = res;
        #1;
        expWe  = !res && cs && !rw && a[4] && a[2];
        expIrq = !((mTimFlag && mTimIe) || (mPa7Flag && mPa7Ie));
        obsWe = TIM_WE; obsMode = TIM_MODE; obsFlag = FLAG_OUT; obsIrq = IRQ_N;
        checkOutput("tim_we",   32'(obsWe),   32'(expWe));
        checkOutput("tim_mode", 32'(obsMode), 32'(a[1:0]));
        checkOutput("flag_out", 32'(obsFlag), 32'({mTimFlag, mPa7Flag, 6'b000000}));
        checkOutput("irq_n",    32'(obsIrq),  32'(expIrq));
        @(posedge CLK);
        modelStep(cs, rw, a, pa7, uf, res);
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input bit pa7);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 5'h00, pa7, 0, 0);
    endtask

    initial begin
        bit rcs, rrw, rpa7, ruf, rres;
        bit [4:0] ra;

        // Initial reset cycle; outputs are undefined until the first edge
        CS = 0; RW = 1; A = 5'h00; PA7 = 0; TIM_UF = 0; RES = 1;
        @(posedge CLK);
        modelReset();
        @(negedge CLK);
        applyStimulus(0, 1, 5'h00, 0, 0, 1);

        // Idle after reset
        idle(10, 0);
        checkOutput("idle_irq",  32'(IRQ_N),    32'd1);
        checkOutput("idle_flag", 32'(FLAG_OUT), 32'h00);

        // Timer write, underflow, then timer read clears
        applyStimulus(1, 0, 5'h1E, 0, 0, 0);
        checkOutput("tw_we",   32'(obsWe),   32'd1);
        checkOutput("tw_mode", 32'(obsMode), 32'd2);
        applyStimulus(0, 1, 5'h00, 0, 1, 0);
        checkOutput("uf_flag", 32'(FLAG_OUT), 32'h80);
        checkOutput("uf_irq",  32'(IRQ_N),    32'd0);
        applyStimulus(1, 1, 5'h0C, 0, 0, 0);
        checkOutput("tr_flag", 32'(FLAG_OUT), 32'h00);
        checkOutput("tr_irq",  32'(IRQ_N),    32'd1);

        // Rising edge enabled, measure pin-to-flag latency
        applyStimulus(1, 0, 5'h07, 0, 0, 0);
        idle(3, 0);
        latency = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 5'h00, 1, 0, 0);
            if (latency == 0 && FLAG_OUT == 8'h40) latency = i + 1;
        end
        checkOutput("pa7_latency", 32'(latency), 32'(SS + 1));
        checkOutput("pa7_irq", 32'(IRQ_N), 32'd0);
        applyStimulus(1, 1, 5'h05, 1, 0, 0);
        checkOutput("fr_read", 32'(obsFlag), 32'h40);
        checkOutput("fr_flag", 32'(FLAG_OUT), 32'h00);
        checkOutput("fr_irq",  32'(IRQ_N),    32'd1);

        // Falling polarity: settle low, clear, then pulse with polarity flips while high
        applyStimulus(1, 0, 5'h06, 1, 0, 0);
        idle(5, 0);
        applyStimulus(1, 1, 5'h05, 0, 0, 0);
        idle(5, 1);
        checkOutput("fall_on_rise", 32'(FLAG_OUT), 32'h00);
        applyStimulus(1, 0, 5'h07, 1, 0, 0);
        idle(2, 1);
        applyStimulus(1, 0, 5'h06, 1, 0, 0);
        idle(2, 1);
        checkOutput("flip_no_edge", 32'(FLAG_OUT), 32'h00);
        idle(5, 0);
        checkOutput("fall_edge", 32'(FLAG_OUT), 32'h40);
        applyStimulus(1, 1, 5'h05, 0, 0, 0);

        // Set wins over clear for both flags
        applyStimulus(1, 1, 5'h0C, 0, 1, 0);
        applyStimulus(1, 0, 5'h07, 0, 0, 0);
        idle(3, 0);
        applyStimulus(0, 1, 5'h00, 1, 0, 0);
        for (int i = 1; i < SS; i++) applyStimulus(0, 1, 5'h00, 1, 0, 0);
        applyStimulus(1, 1, 5'h05, 1, 0, 0);
        checkOutput("set_wins", 32'(FLAG_OUT), 32'hC0);
        checkOutput("set_wins_irq", 32'(IRQ_N), 32'd0);

        // Reset overrides flags and enables; later underflow is flagged but masked
        applyStimulus(0, 1, 5'h00, 1, 0, 1);
        checkOutput("res_irq",  32'(IRQ_N),    32'd1);
        checkOutput("res_flag", 32'(FLAG_OUT), 32'h00);
        applyStimulus(0, 1, 5'h00, 1, 1, 0);
        checkOutput("masked_flag", 32'(FLAG_OUT), 32'h80);
        checkOutput("masked_irq",  32'(IRQ_N),    32'd1);

        // Randomized traffic against the model
        rpa7 = 1;
        for (int n = 0; n < 3000; n++) begin
            rcs  = ($urandom_range(0, 2) == 0);
            rrw  = $urandom_range(0, 1) == 1;
            ra   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) rpa7 = !rpa7;
            ruf  = ($urandom_range(0, 7) == 0);
            rres = ($urandom_range(0, 63) == 0);
            applyStimulus(rcs, rrw, ra, rpa7, ruf, rres);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
